display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Upstream feeder for the seven-segment digit decoder.
- Accepts an 8-bit grade value over a valid/ready handshake and clamps it to a legal maximum.
- Holds the value stable for whole scan frames, so no digit tears mid-frame.
- Generates the time-multiplexed 2-bit digit-select sequence; leading-zero digit slots drive the "all anodes off" select code.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit slot stays active; legal range >= 1.
MAX_VALUE, 100, largest value passed downstream; legal range 0..199.
BLANK_LZ, 1, 1 = blank leading-zero tens/hundreds slots; 0 = always show all three digits.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
value_in  input  8  new value to display.
value_valid  input  1  value_in is valid this cycle.
value_ready  output  1  block can accept value_in this cycle.
bin_out  output  8  displayed value, fed to the decoder's binary input.
anode_sel  output  2  digit select, fed to the decoder: 00 ones, 01 tens, 10 hundreds, 11 blank.
frame_tick  output  1  one-cycle pulse on the cycle the scan wraps from hundreds back to ones.
clamped  output  1  the last accepted value exceeded MAX_VALUE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n; it is sampled only on the rising edge of clk.
- Reset values:
  - prescaler = 0, slot = 0.
  - bin_out = 0, pending register empty.
  - clamped = 0, frame_tick = 0.
  - value_ready = 0 while rst_n is low; handshakes are ignored during reset.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - The terminal-count cycle is "slot_adv".
  - With REFRESH_DIV = 1, slot_adv is asserted every cycle.
- Slot counter:
  - Advances on slot_adv: 0 -> 1 -> 2 -> 0.
  - The value 3 is never held.
- Frame boundary:
  - "wrap" = slot_adv while slot == 2.
  - frame_tick is registered and is high for exactly the cycle after the wrap edge, i.e. the first cycle of slot 0.
- Handshake:
  - value_ready = !pending_full (and rst_n high).
  - Transfer occurs when value_valid && value_ready on a rising edge.
  - On transfer: pending <= min(value_in, MAX_VALUE), pending_full <= 1, clamped <= (value_in > MAX_VALUE).
  - clamped holds until the next transfer.
- Commit:
  - On the wrap edge, if pending_full: bin_out <= pending and pending_full <= 0.
  - If pending is empty at the wrap edge, bin_out holds.
  - Simultaneous transfer and wrap: possible only when pending was empty. The new value lands in pending and commits at the next wrap, not the current one.
- Latency:
  - A value accepted mid-frame appears on bin_out after the next wrap.
  - Worst case is 3*REFRESH_DIV cycles.
- anode_sel:
  - Combinational from registered slot and bin_out; glitch-free because both sources are flops.
  - slot 0 -> 00 (always shown).
  - slot 1 -> 11 if BLANK_LZ && bin_out < 10, else 01.
  - slot 2 -> 11 if BLANK_LZ && bin_out < 100, else 10.
- Width and arithmetic:
  - The prescaler is wide enough for REFRESH_DIV-1 (minimum 1 bit).
  - The clamp compare is unsigned 8-bit.
- Mid-operation reset:
  - Discards pending data, zeroes bin_out and restarts the scan at slot 0 on the next edge.
  - No frame_tick is generated by reset.
- Value held off (valid low or no transfer): the scan continues indefinitely with the current bin_out.

Test Plan:
- REFRESH_DIV=4, release reset, no input -> bin_out=0; anode_sel sequence 00 x4, 11 x4, 11 x4, repeating; frame_tick every 12 cycles, first at cycle 12.
- Send 87 mid-slot-1 -> value_ready drops next cycle; bin_out stays 0 until the wrap, then 87; anode_sel sequence 00, 01, 11; value_ready returns to 1.
- Send 150 -> clamped=1; after the wrap bin_out=100; anode_sel sequence 00, 01, 10. Then send 42 -> clamped=0.
- Send 5 then hold 42 valid before the wrap -> 42 stalls with value_ready=0. At the wrap bin_out=5 and 42 is accepted on the following cycle. At the next wrap bin_out=42.
- Assert value_valid on exactly the wrap edge with pending empty (value 9) -> bin_out unchanged this frame; 9 appears one frame later.
- With bin_out=100, assert rst_n=0 for one cycle during slot 2 with 55 pending -> next cycle slot=0, bin_out=0, pending empty; 55 never appears.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Display scan controller: accepts a grade value over valid/ready, clamps it,
// commits it to the display only at frame boundaries, and sequences the
// 2-bit digit select with optional leading-zero blanking.
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned MAX_VALUE   = 100,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value_in,
  input  logic       value_valid,
  output logic       value_ready,
  output logic [7:0] bin_out,
  output logic [1:0] anode_sel,
  output logic       frame_tick,
  output logic       clamped
);

  localparam int unsigned       PrescW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(REFRESH_DIV - 1);
  localparam logic [PrescW-1:0] PrescOne  = PrescW'(1);
  localparam logic [7:0]        MaxVal    = 8'(MAX_VALUE);

  typedef enum logic [1:0] {
    SlotOnes = 2'd0,
    SlotTens = 2'd1,
    SlotHund = 2'd2
  } slot_e;

  logic [PrescW-1:0] presc_q, presc_d;
  slot_e             slot_q, slot_d;
  logic [7:0]        bin_q, bin_d;
  logic [7:0]        pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic              clamped_q, clamped_d;
  logic              tick_q, tick_d;

  logic slot_adv;
  logic wrap;
  logic xfer;

  // Next-state: prescaler, slot sequencing, handshake capture and frame commit.
  always_comb begin
    slot_adv    = (presc_q == PrescLast);
    wrap        = slot_adv && (slot_q == SlotHund);
    xfer        = value_valid && value_ready;

    presc_d     = slot_adv ? '0 : presc_q + PrescOne;
    slot_d      = slot_q;
    bin_d       = bin_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    clamped_d   = clamped_q;
    tick_d      = wrap;

    if (slot_adv) begin
      unique case (slot_q)
        SlotOnes: slot_d = SlotTens;
        SlotTens: slot_d = SlotHund;
        default:  slot_d = SlotOnes;
      endcase
    end

    if (wrap && pend_full_q) begin
      bin_d       = pend_q;
      pend_full_d = 1'b0;
    end

    // A transfer only happens with pending empty, so it never collides with
    // a commit; a value landing on the wrap edge waits for the next frame.
    if (xfer) begin
      pend_d      = (value_in > MaxVal) ? MaxVal : value_in;
      pend_full_d = 1'b1;
      clamped_d   = (value_in > MaxVal);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q     <= '0;
      slot_q      <= SlotOnes;
      bin_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      clamped_q   <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      slot_q      <= slot_d;
      bin_q       <= bin_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      clamped_q   <= clamped_d;
      tick_q      <= tick_d;
    end
  end

  // Digit select decoded from flops only, blanking leading-zero slots.
  always_comb begin
    anode_sel = 2'b11;
    unique case (slot_q)
      SlotOnes: anode_sel = 2'b00;
      SlotTens: anode_sel = (BLANK_LZ && (bin_q < 8'd10))  ? 2'b11 : 2'b01;
      SlotHund: anode_sel = (BLANK_LZ && (bin_q < 8'd100)) ? 2'b11 : 2'b10;
      default:  anode_sel = 2'b11;
    endcase
  end

  assign value_ready = rst_n && !pend_full_q;
  assign bin_out     = bin_q;
  assign frame_tick  = tick_q;
  assign clamped     = clamped_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with a queue-based scoreboard.
module tb_display_scan_ctrl;

  localparam int unsigned R   = 4;
  localparam int unsigned MAX = 100;
  localparam int unsigned P   = 3 * R;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value_in = '0;
  logic       value_valid = 1'b0;
  logic       value_ready;
  logic [7:0] bin_out;
  logic [1:0] anode_sel;
  logic       frame_tick;
  logic       clamped;

  display_scan_ctrl #(
    .REFRESH_DIV(R),
    .MAX_VALUE  (MAX),
    .BLANK_LZ   (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .bin_out    (bin_out),
    .anode_sel  (anode_sel),
    .frame_tick (frame_tick),
    .clamped    (clamped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  v;
    int unsigned tag;
  } ent_t;

  ent_t        sb[$];
  int unsigned checks = 0;
  int unsigned fails  = 0;
  bit          started = 1'b0;

  // Reference model state: cycle position since reset, frames completed,
  // whether a value is waiting, and the last accepted clamp flag.
  int unsigned m_n = 0;
  int unsigned m_frame = 0;
  int unsigned m_epoch = 0;
  bit          m_full = 1'b0;
  bit          m_clamp = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sat(input logic [7:0] v);
    return (v > 8'(MAX)) ? 8'(MAX) : v;
  endfunction

  // Reference model: advances at each clock edge from the sampled inputs.
  initial begin
    bit wrap;
    bit nfull;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_n     = 0;
        m_frame = 0;
        m_full  = 1'b0;
        m_clamp = 1'b0;
        m_epoch++;
      end else begin
        wrap  = (m_n % P) == (P - 1);
        nfull = m_full;
        if (wrap && m_full) nfull = 1'b0;
        if (value_valid && !m_full) begin
          // Accepted on the wrap edge itself means it belongs to the next frame.
          sb.push_back('{v: sat(value_in), tag: (wrap ? m_frame + 1 : m_frame)});
          nfull   = 1'b1;
          m_clamp = (value_in > 8'(MAX));
        end
        m_full = nfull;
        if (wrap) m_frame++;
        m_n++;
      end
    end
  end

  // Monitor: on each frame start, pop a committed value if one is due, and
  // compare all outputs against the expected display state every cycle.
  initial begin
    logic [7:0]  m_disp;
    int unsigned last_epoch;
    bit          exp_tick;
    int unsigned slot;
    logic [1:0]  exp_an;
    m_disp     = '0;
    last_epoch = 0;
    wait (started);
    forever begin
      @(negedge clk);
      if (m_epoch != last_epoch) begin
        last_epoch = m_epoch;
        sb.delete();
        m_disp = '0;
      end
      exp_tick = ((m_n % P) == 0) && (m_n != 0);
      if (exp_tick && (sb.size() > 0) && (sb[0].tag < m_frame)) begin
        m_disp = sb[0].v;
        void'(sb.pop_front());
      end
      slot = (m_n / R) % 3;
      if (slot == 0)      exp_an = 2'b00;
      else if (slot == 1) exp_an = (m_disp < 8'd10)  ? 2'b11 : 2'b01;
      else                exp_an = (m_disp < 8'd100) ? 2'b11 : 2'b10;
      chk("frame_tick",  {7'd0, frame_tick},  {7'd0, exp_tick});
      chk("bin_out",     bin_out,             m_disp);
      chk("clamped",     {7'd0, clamped},     {7'd0, m_clamp});
      chk("value_ready", {7'd0, value_ready}, {7'd0, (rst_n && !m_full)});
      chk("anode_sel",   {6'd0, anode_sel},   {6'd0, exp_an});
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait until the current cycle sits at the given position within the frame.
  task automatic wait_phase(input int unsigned ph);
    for (int k = 0; k < 2 * P; k++) begin
      if ((m_n % P) == ph) return;
      @(posedge clk);
      #1;
    end
    checks++;
    fails++;
    $display("FAIL wait_phase: phase %0d not reached, at %0d", ph, m_n % P);
  endtask

  // Hold valid until a transfer edge, bounded.
  task automatic send(input logic [7:0] v);
    bit rdy;
    bit done;
    done        = 1'b0;
    value_in    = v;
    value_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      rdy = value_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        done = 1'b1;
        break;
      end
    end
    value_valid = 1'b0;
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: value %0d got no ready, required accept", v);
    end
  endtask

  initial begin
    int unsigned r;
    repeat (3) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    started = 1'b1;

    idle(30);
    wait_phase(5);
    send(8'd87);
    idle(30);
    send(8'd150);
    idle(30);
    send(8'd42);
    idle(20);
    send(8'd5);
    send(8'd42);
    idle(40);
    wait_phase(11);
    send(8'd9);
    idle(40);

    send(8'd100);
    idle(30);
    wait_phase(3);
    send(8'd55);
    wait_phase(9);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(30);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if (r < 12) begin
        send(8'($urandom_range(0, 255)));
      end else if (r < 19) begin
        idle($urandom_range(1, 15));
      end else begin
        rst_n = 1'b0;
        idle($urandom_range(1, 2));
        rst_n = 1'b1;
      end
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
